// File: rtl/ecdsa_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ecdsa_reg_pkg
// Brief   : Shared widths, register offsets, decode types and helpers for the
//           ECDSA AXI4-Lite register file.
// Revision: 1.0 - initial release
// ============================================================================
package ecdsa_reg_pkg;
  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 64;
  localparam int STRB_W   = DATA_W / 8;
  localparam int OP_W     = 256;
  localparam int OP_WORDS = OP_W / DATA_W;

  localparam logic [ADDR_W-1:0] OFF_CTRL   = 16'h0000;
  localparam logic [ADDR_W-1:0] OFF_STATUS = 16'h0008;
  localparam logic [ADDR_W-1:0] OFF_KEY    = 16'h0100;
  localparam logic [ADDR_W-1:0] OFF_HASH   = 16'h0120;
  localparam logic [ADDR_W-1:0] OFF_NONCE  = 16'h0140;
  localparam logic [ADDR_W-1:0] OFF_SIG_R  = 16'h0200;
  localparam logic [ADDR_W-1:0] OFF_SIG_S  = 16'h0220;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    SEL_CTRL, SEL_STATUS, SEL_KEY, SEL_HASH, SEL_NONCE, SEL_SIG_R, SEL_SIG_S, SEL_NONE
  } reg_sel_t;

  typedef struct packed {
    reg_sel_t                    sel;
    logic [$clog2(OP_WORDS)-1:0] word;
    logic                        ro;
    logic                        err;
  } reg_dec_t;

  typedef enum logic [0:0] {W_IDLE, W_RESP} wstate_t;
  typedef enum logic [0:0] {R_IDLE, R_RESP} rstate_t;

  function automatic logic [DATA_W-1:0] apply_strb(input logic [DATA_W-1:0] old_v,
                                                   input logic [DATA_W-1:0] new_v,
                                                   input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] res;
    res = old_v;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction
endpackage
`default_nettype wire

// File: rtl/ecdsa_axil_regs_if.sv
`default_nettype none
// ============================================================================
// Module  : ecdsa_axil_regs_if
// Brief   : AXI4-Lite channel bundle between the crossbar port and the ECDSA
//           register file.
// Revision: 1.0 - initial release
// ============================================================================
interface ecdsa_axil_regs_if;
  import ecdsa_reg_pkg::*;

  logic [ADDR_W-1:0] awaddr_i;
  logic              awvalid_i;
  logic              awready_o;
  logic [DATA_W-1:0] wdata_i;
  logic [STRB_W-1:0] wstrb_i;
  logic              wvalid_i;
  logic              wready_o;
  logic [1:0]        bresp_o;
  logic              bvalid_o;
  logic              bready_i;
  logic [ADDR_W-1:0] araddr_i;
  logic              arvalid_i;
  logic              arready_o;
  logic [DATA_W-1:0] rdata_o;
  logic [1:0]        rresp_o;
  logic              rvalid_o;
  logic              rready_i;

  modport slave (
    input  awaddr_i, awvalid_i, wdata_i, wstrb_i, wvalid_i, bready_i,
           araddr_i, arvalid_i, rready_i,
    output awready_o, wready_o, bresp_o, bvalid_o, arready_o, rdata_o,
           rresp_o, rvalid_o
  );

  modport master (
    output awaddr_i, awvalid_i, wdata_i, wstrb_i, wvalid_i, bready_i,
           araddr_i, arvalid_i, rready_i,
    input  awready_o, wready_o, bresp_o, bvalid_o, arready_o, rdata_o,
           rresp_o, rvalid_o
  );
endinterface
`default_nettype wire

// File: rtl/ecdsa_reg_decode.sv
`default_nettype none
// ============================================================================
// Module  : ecdsa_reg_decode
// Brief   : Combinational byte-offset decoder: register select, word index,
//           read-only flag and unmapped/misaligned error.
// Revision: 1.0 - initial release
// ============================================================================
module ecdsa_reg_decode
  import ecdsa_reg_pkg::*;
(
  input  logic [ADDR_W-1:0] i_addr,
  output reg_dec_t          o_dec
);
  always_comb begin
    o_dec.sel  = SEL_NONE;
    o_dec.word = i_addr[4:3];
    o_dec.ro   = 1'b0;
    o_dec.err  = 1'b1;
    if (i_addr[2:0] == 3'b000) begin
      o_dec.err = 1'b0;
      if (i_addr == OFF_CTRL)                               o_dec.sel = SEL_CTRL;
      else if (i_addr == OFF_STATUS)                        o_dec.sel = SEL_STATUS;
      else if (i_addr[ADDR_W-1:5] == OFF_KEY[ADDR_W-1:5])   o_dec.sel = SEL_KEY;
      else if (i_addr[ADDR_W-1:5] == OFF_HASH[ADDR_W-1:5])  o_dec.sel = SEL_HASH;
      else if (i_addr[ADDR_W-1:5] == OFF_NONCE[ADDR_W-1:5]) o_dec.sel = SEL_NONCE;
      else if (i_addr[ADDR_W-1:5] == OFF_SIG_R[ADDR_W-1:5]) begin
        o_dec.sel = SEL_SIG_R;
        o_dec.ro  = 1'b1;
      end else if (i_addr[ADDR_W-1:5] == OFF_SIG_S[ADDR_W-1:5]) begin
        o_dec.sel = SEL_SIG_S;
        o_dec.ro  = 1'b1;
      end else begin
        o_dec.err = 1'b1;
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/ecdsa_axil_regs.sv
`default_nettype none
// ============================================================================
// Module  : ecdsa_axil_regs
// Brief   : AXI4-Lite responder and register file for the ECDSA accelerator:
//           operands, control/status, signature capture and interrupt.
// Revision: 1.0 - initial release
// ============================================================================
module ecdsa_axil_regs
  import ecdsa_reg_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  ecdsa_axil_regs_if.slave  axi,
  output logic [OP_W-1:0]   key_o,
  output logic [OP_W-1:0]   hash_o,
  output logic [OP_W-1:0]   nonce_o,
  input  logic [OP_W-1:0]   sig_r_i,
  input  logic [OP_W-1:0]   sig_s_i,
  output logic              core_start_o,
  input  logic              core_busy_i,
  input  logic              core_done_i,
  input  logic              core_err_i,
  output logic              irq_o
);
  logic [OP_WORDS-1:0][DATA_W-1:0] r_key, r_hash, r_nonce, r_sig_r, r_sig_s;
  logic r_start, r_irq_en, r_done, r_err, r_irq;
  logic w_busy;

  wstate_t r_wstate, w_wstate_nx;
  logic r_awready, w_awready_nx, r_wready, w_wready_nx, r_bvalid, w_bvalid_nx;
  logic r_aw_held, w_aw_held_nx, r_w_held, w_w_held_nx;
  logic [1:0] r_bresp, w_bresp_nx;
  logic [ADDR_W-1:0] r_awaddr, w_waddr;
  logic [DATA_W-1:0] r_wdata, w_wdata;
  logic [STRB_W-1:0] r_wstrb, w_wstrb;
  logic w_aw_hs, w_w_hs, w_commit, w_is_op, w_wr_err, w_wr_ok;
  logic w_start_req, w_start_fire, w_start_rej, w_status_wr;
  reg_dec_t w_wdec, w_rdec;

  rstate_t r_rstate, w_rstate_nx;
  logic r_arready, w_arready_nx, r_rvalid, w_rvalid_nx, w_ar_hs, w_unused_rd_ro;
  logic [1:0] r_rresp, w_rresp_nx;
  logic [DATA_W-1:0] r_rdata, w_rdata_nx, w_rd_word;

  assign w_busy = core_busy_i | r_start;

  // A channel already captured in an earlier cycle supplies its held copy.
  assign w_aw_hs  = axi.awvalid_i & r_awready;
  assign w_w_hs   = axi.wvalid_i & r_wready;
  assign w_waddr  = r_aw_held ? r_awaddr : axi.awaddr_i;
  assign w_wdata  = r_w_held ? r_wdata : axi.wdata_i;
  assign w_wstrb  = r_w_held ? r_wstrb : axi.wstrb_i;
  assign w_commit = (r_wstate == W_IDLE) & (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);

  ecdsa_reg_decode u_wr_dec (.i_addr(w_waddr),      .o_dec(w_wdec));
  ecdsa_reg_decode u_rd_dec (.i_addr(axi.araddr_i), .o_dec(w_rdec));
  assign w_unused_rd_ro = w_rdec.ro;

  assign w_is_op      = (w_wdec.sel == SEL_KEY) | (w_wdec.sel == SEL_HASH) | (w_wdec.sel == SEL_NONCE);
  assign w_wr_err     = w_wdec.err | w_wdec.ro | (w_is_op & w_busy);
  assign w_wr_ok      = w_commit & ~w_wr_err;
  assign w_start_req  = w_wr_ok & (w_wdec.sel == SEL_CTRL) & w_wstrb[0] & w_wdata[0];
  assign w_start_fire = w_start_req & ~w_busy;
  assign w_start_rej  = w_start_req & w_busy;
  assign w_status_wr  = w_wr_ok & (w_wdec.sel == SEL_STATUS) & w_wstrb[0];

  always_comb begin
    w_wstate_nx  = r_wstate;
    w_awready_nx = r_awready;
    w_wready_nx  = r_wready;
    w_bvalid_nx  = r_bvalid;
    w_bresp_nx   = r_bresp;
    w_aw_held_nx = r_aw_held;
    w_w_held_nx  = r_w_held;
    case (r_wstate)
      W_IDLE: begin
        if (w_commit) begin
          w_wstate_nx  = W_RESP;
          w_awready_nx = 1'b0;
          w_wready_nx  = 1'b0;
          w_bvalid_nx  = 1'b1;
          w_bresp_nx   = w_wr_err ? RESP_SLVERR : RESP_OKAY;
          w_aw_held_nx = 1'b0;
          w_w_held_nx  = 1'b0;
        end else begin
          w_aw_held_nx = r_aw_held | w_aw_hs;
          w_w_held_nx  = r_w_held | w_w_hs;
          w_awready_nx = ~w_aw_held_nx;
          w_wready_nx  = ~w_w_held_nx;
        end
      end
      W_RESP: begin
        if (axi.bready_i) begin
          w_wstate_nx  = W_IDLE;
          w_bvalid_nx  = 1'b0;
          w_awready_nx = 1'b1;
          w_wready_nx  = 1'b1;
        end
      end
      default: w_wstate_nx = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else begin
      r_wstate  <= w_wstate_nx;
      r_awready <= w_awready_nx;
      r_wready  <= w_wready_nx;
      r_bvalid  <= w_bvalid_nx;
      r_bresp   <= w_bresp_nx;
      r_aw_held <= w_aw_held_nx;
      r_w_held  <= w_w_held_nx;
      if (w_aw_hs) r_awaddr <= axi.awaddr_i;
      if (w_w_hs) begin
        r_wdata <= axi.wdata_i;
        r_wstrb <= axi.wstrb_i;
      end
    end
  end

  // Core set events are ORed after the clear so they win a same-cycle W1C.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_key    <= '0;
      r_hash   <= '0;
      r_nonce  <= '0;
      r_sig_r  <= '0;
      r_sig_s  <= '0;
      r_start  <= 1'b0;
      r_irq_en <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_start <= w_start_fire;
      r_done  <= core_done_i | (r_done & ~(w_status_wr & w_wdata[1]));
      r_err   <= core_err_i | w_start_rej | (r_err & ~(w_status_wr & w_wdata[2]));
      r_irq   <= r_done & r_irq_en;
      if (w_wr_ok && (w_wdec.sel == SEL_CTRL) && w_wstrb[0]) r_irq_en <= w_wdata[1];
      if (w_wr_ok) begin
        case (w_wdec.sel)
          SEL_KEY:   r_key[w_wdec.word]   <= apply_strb(r_key[w_wdec.word], w_wdata, w_wstrb);
          SEL_HASH:  r_hash[w_wdec.word]  <= apply_strb(r_hash[w_wdec.word], w_wdata, w_wstrb);
          SEL_NONCE: r_nonce[w_wdec.word] <= apply_strb(r_nonce[w_wdec.word], w_wdata, w_wstrb);
          default: ;
        endcase
      end
      if (core_done_i) begin
        r_sig_r <= sig_r_i;
        r_sig_s <= sig_s_i;
      end
    end
  end

  always_comb begin
    w_rd_word = '0;
    case (w_rdec.sel)
      SEL_CTRL:   w_rd_word[1] = r_irq_en;
      SEL_STATUS: w_rd_word[2:0] = {r_err, r_done, w_busy};
      SEL_KEY:    w_rd_word = r_key[w_rdec.word];
      SEL_HASH:   w_rd_word = r_hash[w_rdec.word];
      SEL_NONCE:  w_rd_word = r_nonce[w_rdec.word];
      SEL_SIG_R:  w_rd_word = r_sig_r[w_rdec.word];
      SEL_SIG_S:  w_rd_word = r_sig_s[w_rdec.word];
      default:    w_rd_word = '0;
    endcase
  end

  assign w_ar_hs = axi.arvalid_i & r_arready;

  always_comb begin
    w_rstate_nx  = r_rstate;
    w_arready_nx = r_arready;
    w_rvalid_nx  = r_rvalid;
    w_rresp_nx   = r_rresp;
    w_rdata_nx   = r_rdata;
    case (r_rstate)
      R_IDLE: begin
        w_arready_nx = 1'b1;
        if (w_ar_hs) begin
          w_rstate_nx  = R_RESP;
          w_arready_nx = 1'b0;
          w_rvalid_nx  = 1'b1;
          w_rdata_nx   = w_rd_word;
          w_rresp_nx   = w_rdec.err ? RESP_SLVERR : RESP_OKAY;
        end
      end
      R_RESP: begin
        if (axi.rready_i) begin
          w_rstate_nx  = R_IDLE;
          w_rvalid_nx  = 1'b0;
          w_arready_nx = 1'b1;
        end
      end
      default: w_rstate_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= '0;
    end else begin
      r_rstate  <= w_rstate_nx;
      r_arready <= w_arready_nx;
      r_rvalid  <= w_rvalid_nx;
      r_rresp   <= w_rresp_nx;
      r_rdata   <= w_rdata_nx;
    end
  end

  assign axi.awready_o = r_awready;
  assign axi.wready_o  = r_wready;
  assign axi.bvalid_o  = r_bvalid;
  assign axi.bresp_o   = r_bresp;
  assign axi.arready_o = r_arready;
  assign axi.rvalid_o  = r_rvalid;
  assign axi.rresp_o   = r_rresp;
  assign axi.rdata_o   = r_rdata;
  assign key_o         = r_key;
  assign hash_o        = r_hash;
  assign nonce_o       = r_nonce;
  assign core_start_o  = r_start;
  assign irq_o         = r_irq;
endmodule
`default_nettype wire
